// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// This is the pipeline hazard and redirect controller for the five-stage core.
// It watches the decode-stage source registers and the EX-side outputs of the
// ID/EX register. From these it drives the fetch and decode enables and
// flushes:
//   - A load-use hazard inserts exactly one bubble into ID/EX. PC and IF/ID
//     hold during that cycle.
//   - A control-flow redirect resolved in EX flushes IF/ID for
//     REDIRECT_BUBBLES cycles. This covers fetch latency. ID/EX is flushed
//     only in the first of those cycles.
// The outputs are combinational, so a hazard is answered in the same cycle it
// is seen.
//
// Parameters
//   REDIRECT_BUBBLES  IF/ID flush cycles per redirect (legal 1..4)
//
// Optional feature
//   HAZARD_PERF_CNT_EN  defined   : performance counters are implemented
//                       undefined : counter ports are tied to 32'd0
//
// Ports
//   clk                in  1   rising-edge clock
//   reset              in  1   asynchronous, active-high reset
//   id_rs1_addr        in  5   rs1 of the instruction in ID
//   id_rs2_addr        in  5   rs2 of the instruction in ID
//   id_uses_rs1        in  1   ID instruction reads rs1
//   id_uses_rs2        in  1   ID instruction reads rs2
//   ex_rd              in  5   rd of the instruction in EX
//   ex_mem_read        in  1   instruction in EX is a load
//   ex_redirect        in  1   EX resolved a taken control transfer
//   pc_write           out 1   PC enable
//   if_id_write        out 1   IF/ID enable
//   if_id_flush        out 1   IF/ID clear-to-bubble
//   id_ex_flush        out 1   ID/EX clear-to-bubble
//   load_stall         out 1   load-use bubble inserted this cycle
//   perf_stall_cnt     out 32  load-use stall cycle count
//   perf_redirect_cnt  out 32  redirect event count
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REDIRECT_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_redirect,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        load_stall,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_redirect_cnt
);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    // The redirect cycle itself is the first flush cycle. The REDIRECT state
    // only has to cover the remaining ones.
    localparam logic [2:0] BUB_RELOAD   = 3'(REDIRECT_BUBBLES - 1);
    localparam bit         MULTI_BUBBLE = (REDIRECT_BUBBLES > 1);

    state_t     state_r;
    state_t     state_s;
    logic [2:0] bub_left_r;
    logic [2:0] bub_left_s;
    logic       lu_s;

    // Load-use detection. Register x0 never carries a dependency.
    always_comb begin
        lu_s = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && (id_rs1_addr == ex_rd)) ||
                (id_uses_rs2 && (id_rs2_addr == ex_rd)));
    end

    // Output decode and next-state logic. The priority is reset, then
    // REDIRECT, then ex_redirect, then load-use.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        load_stall  = 1'b0;
        state_s     = state_r;
        bub_left_s  = bub_left_r;

        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_s     = ST_RUN;
            bub_left_s  = 3'd0;
        end else begin
            case (state_r)
                ST_REDIRECT: begin
                    // EX holds only bubbles here, so new redirects and
                    // load-use matches cannot be real.
                    if_id_flush = 1'b1;
                    if (bub_left_r <= 3'd1) begin
                        state_s    = ST_RUN;
                        bub_left_s = 3'd0;
                    end else begin
                        state_s    = ST_REDIRECT;
                        bub_left_s = bub_left_r - 3'd1;
                    end
                end
                ST_RUN: begin
                    if (ex_redirect) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        if (MULTI_BUBBLE) begin
                            state_s    = ST_REDIRECT;
                            bub_left_s = BUB_RELOAD;
                        end else begin
                            state_s    = ST_RUN;
                            bub_left_s = 3'd0;
                        end
                    end else if (lu_s) begin
                        // Hold PC and IF/ID. The bubble that now enters
                        // ID/EX clears the hazard by the next cycle.
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        load_stall  = 1'b1;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end
                end
                default: begin
                    // An unreachable encoding recovers to a flushed RUN.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_s     = ST_RUN;
                    bub_left_s  = 3'd0;
                end
            endcase
        end
    end

    // State and bubble-counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_RUN;
            bub_left_r <= 3'd0;
        end else begin
            state_r    <= state_s;
            bub_left_r <= bub_left_s;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] redirect_cnt_r;
    logic        redir_evt_s;

    // A redirect is counted only when it is accepted, which happens in RUN.
    always_comb begin
        redir_evt_s = !reset && (state_r == ST_RUN) && ex_redirect;
    end

    // Performance counters. Both wrap modulo 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r    <= 32'd0;
            redirect_cnt_r <= 32'd0;
        end else begin
            if (load_stall) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (redir_evt_s) begin
                redirect_cnt_r <= redirect_cnt_r + 32'd1;
            end else begin
                redirect_cnt_r <= redirect_cnt_r;
            end
        end
    end

    assign perf_stall_cnt    = stall_cnt_r;
    assign perf_redirect_cnt = redirect_cnt_r;
`else
    assign perf_stall_cnt    = 32'd0;
    assign perf_redirect_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl, built with REDIRECT_BUBBLES = 3.
// A reference model follows the controller's rules as a count of remaining
// wrong-path flush cycles plus two event tallies. Directed scenarios run
// first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int BUB = 3;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_redirect;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        load_stall;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_redirect_cnt;
    logic [4:0]  ctrl;

    // Packed control outputs: {pc_write, if_id_write, if_id_flush, id_ex_flush, load_stall}.
    localparam logic [4:0] C_RESET  = 5'b00110;
    localparam logic [4:0] C_REDIR  = 5'b11110;
    localparam logic [4:0] C_HOLD   = 5'b11100;
    localparam logic [4:0] C_STALL  = 5'b00011;
    localparam logic [4:0] C_NORMAL = 5'b11000;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          flush_left = 0;
    logic [31:0] m_stalls = 32'd0;
    logic [31:0] m_redirs = 32'd0;

    hazard_ctrl #(.REDIRECT_BUBBLES(BUB)) dut (
        .clk               (clk),
        .reset             (reset),
        .id_rs1_addr       (id_rs1_addr),
        .id_rs2_addr       (id_rs2_addr),
        .id_uses_rs1       (id_uses_rs1),
        .id_uses_rs2       (id_uses_rs2),
        .ex_rd             (ex_rd),
        .ex_mem_read       (ex_mem_read),
        .ex_redirect       (ex_redirect),
        .pc_write          (pc_write),
        .if_id_write       (if_id_write),
        .if_id_flush       (if_id_flush),
        .id_ex_flush       (id_ex_flush),
        .load_stall        (load_stall),
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
    );

    assign ctrl = {pc_write, if_id_write, if_id_flush, id_ex_flush, load_stall};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input logic [31:0] v);
        return PERF ? v : 32'd0;
    endfunction

    // Does the instruction in ID depend on a load still sitting in EX?
    function automatic bit model_lu();
        bit dep1;
        bit dep2;
        dep1 = id_uses_rs1 && (id_rs1_addr == ex_rd);
        dep2 = id_uses_rs2 && (id_rs2_addr == ex_rd);
        return ex_mem_read && (ex_rd != 5'd0) && (dep1 || dep2);
    endfunction

    function automatic logic [4:0] model_ctrl();
        if (reset)            return C_RESET;
        if (flush_left > 0)   return C_HOLD;
        if (ex_redirect)      return C_REDIR;
        if (model_lu())       return C_STALL;
        return C_NORMAL;
    endfunction

    // The model advances one clock: a redirect leaves BUB-1 further flush cycles.
    task automatic model_step();
        if (reset) begin
            flush_left = 0;
            m_stalls   = 32'd0;
            m_redirs   = 32'd0;
        end else if (flush_left > 0) begin
            flush_left--;
        end else if (ex_redirect) begin
            flush_left = BUB - 1;
            m_redirs++;
        end else if (model_lu()) begin
            m_stalls++;
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic mr, input logic rdr);
        id_rs1_addr = rs1;
        id_rs2_addr = rs2;
        id_uses_rs1 = u1;
        id_uses_rs2 = u2;
        ex_rd       = rd;
        ex_mem_read = mr;
        ex_redirect = rdr;
    endtask

    // One clock: check outputs mid-cycle, then advance the model on the edge.
    task automatic do_cycle(input string tag);
        @(negedge clk);
        check({tag, "/ctrl"}, 32'(ctrl), 32'(model_ctrl()));
        check({tag, "/stall_cnt"}, perf_stall_cnt, cnt_exp(m_stalls));
        check({tag, "/redir_cnt"}, perf_redirect_cnt, cnt_exp(m_redirs));
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        check("reset_ctrl", 32'(ctrl), 32'(C_RESET));
        do_cycle("reset");
        do_cycle("reset");
        reset = 1'b0;

        // Load-use on rs2 is followed by the bubble clearing the hazard.
        drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
        do_cycle("lu");
        check("lu_cnt", perf_stall_cnt, cnt_exp(32'd1));
        drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        do_cycle("lu_after");

        // x0 and unused operands never stall.
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
        do_cycle("x0");
        drive(5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
        do_cycle("unused_rs1");

        // A redirect with a second pulse arriving inside the flush window.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        do_cycle("redir1");
        do_cycle("redir2_pulse");
        drive(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        do_cycle("redir3_lu_ignored");
        check("redir_cnt", perf_redirect_cnt, cnt_exp(32'd1));
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        do_cycle("redir_done");

        // A simultaneous redirect and load-use: the redirect wins.
        drive(5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1);
        do_cycle("prio");
        check("prio_stall_cnt", perf_stall_cnt, cnt_exp(32'd1));
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        do_cycle("prio_drain");
        do_cycle("prio_drain");

        // Reset asserted between edges while in REDIRECT.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        do_cycle("ar_redir");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        reset = 1'b1;
        flush_left = 0;
        m_stalls   = 32'd0;
        m_redirs   = 32'd0;
        #1;
        check("async_rst_ctrl", 32'(ctrl), 32'(C_RESET));
        check("async_rst_cnt", perf_redirect_cnt, 32'd0);
        do_cycle("ar_hold");
        reset = 1'b0;
        do_cycle("ar_post");

        // Randomized traffic. A small register range makes matches frequent.
        for (int i = 0; i < 600; i++) begin
            drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                flush_left = 0;
                m_stalls   = 32'd0;
                m_redirs   = 32'd0;
            end else begin
                reset = 1'b0;
            end
            do_cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
